mem_write_loader: RTL and testbench

- Host-side writer for the per-channel memory-write port that drives the processor command memories and the element envelope memory.
- Accepts a 32-bit valid/ready word stream made of a header word followed by payload words.
- Produces the 13-bit address, 32-bit data and write-enable sequence.
- In command mode, each 128-bit command is split across the four 32-bit command-memory lanes at a single buffer address. In wave mode, words go to consecutive envelope addresses.

---
 rtl/mem_write_loader_pkg.sv | 44 ++++
 rtl/mem_write_addr_gen.sv | 51 +++++
 rtl/mem_write_loader.sv | 145 ++++++++++++++
 tb/tb_mem_write_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_loader_pkg.sv
// Shared header layout, state/mode encodings and address-map constants for the
// per-channel memory-write loader.
package mem_write_loader_pkg;

    localparam int HDR_MODE_BIT  = 31;
    localparam int HDR_LEN_LSB   = 16;
    localparam int HDR_LEN_W     = 12;
    localparam int HDR_START_LSB = 0;
    localparam int HDR_START_W   = 12;

    localparam int CMD_BUF_W   = 8;
    localparam int CMD_SEL_BIT = 12;
    localparam int LANE_LSB    = 8;

    typedef enum logic {
        MODE_CMD  = 1'b0,
        MODE_WAVE = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // A header is bad when its last addressed location falls outside the
    // target memory; sums carry one spare bit so the overflow is visible.
    function automatic logic hdr_is_bad(
        input logic                   mode_wave,
        input logic [HDR_START_W-1:0] start,
        input logic [HDR_LEN_W-1:0]   len
    );
        logic [HDR_START_W:0] cmd_sum;
        logic [HDR_START_W:0] wave_sum;
        cmd_sum  = {{(HDR_START_W-CMD_BUF_W+1){1'b0}}, start[CMD_BUF_W-1:0]} + {1'b0, len};
        wave_sum = {1'b0, start} + {1'b0, len};
        if (mode_wave) begin
            return wave_sum[HDR_START_W];
        end
        return (start[HDR_START_W-1:CMD_BUF_W] != '0) ||
               (cmd_sum[HDR_START_W:CMD_BUF_W] != '0);
    endfunction

endpackage

// File: rtl/mem_write_addr_gen.sv
// Combinational address generator: maps payload word index k to a memory-write
// address and flags whether that address lies inside the target memory.
module mem_write_addr_gen
    import mem_write_loader_pkg::*;
#(
    parameter int  CMD_ADDR_WIDTH  = 8,
    parameter int  MEM_TO_CMD      = 4,
    parameter int  WAVE_ADDR_WIDTH = 12,
    localparam int LANE_W          = $clog2(MEM_TO_CMD),
    localparam int IDX_W           = WAVE_ADDR_WIDTH + LANE_W,
    localparam int ADDR_W          = WAVE_ADDR_WIDTH + 1
) (
    input  logic                       mode_wave,
    input  logic [WAVE_ADDR_WIDTH-1:0] start,
    input  logic [IDX_W-1:0]           word_idx,
    output logic [ADDR_W-1:0]          addr,
    output logic                       in_range
);

    localparam int CMD_SUM_W  = WAVE_ADDR_WIDTH + 1;
    localparam int WAVE_SUM_W = IDX_W + 1;

    logic [CMD_SUM_W-1:0]  buf_sum;
    logic [WAVE_SUM_W-1:0] wave_sum;
    logic [LANE_W-1:0]     lane;
    logic                  cmd_ok;
    logic                  wave_ok;

    // Buffer address advances once per full command (every MEM_TO_CMD words).
    assign buf_sum  = CMD_SUM_W'(start[CMD_ADDR_WIDTH-1:0]) + CMD_SUM_W'(word_idx[IDX_W-1:LANE_W]);
    assign wave_sum = WAVE_SUM_W'(start) + WAVE_SUM_W'(word_idx);
    assign lane     = word_idx[LANE_W-1:0];

    assign cmd_ok  = (buf_sum >> CMD_ADDR_WIDTH) == '0;
    assign wave_ok = (wave_sum >> WAVE_ADDR_WIDTH) == '0;

    always_comb begin
        addr     = '0;
        in_range = 1'b0;
        if (mode_wave) begin
            addr[WAVE_ADDR_WIDTH-1:0] = wave_sum[WAVE_ADDR_WIDTH-1:0];
            addr[CMD_SEL_BIT]         = 1'b1;
            in_range                  = wave_ok;
        end else begin
            addr[CMD_ADDR_WIDTH-1:0]    = buf_sum[CMD_ADDR_WIDTH-1:0];
            addr[LANE_LSB +: LANE_W]    = lane;
            in_range                    = cmd_ok;
        end
    end

endmodule

// File: rtl/mem_write_loader.sv
// Header-plus-payload stream loader that issues one registered memory write per
// accepted payload word into the command lanes or the envelope memory.
module mem_write_loader
    import mem_write_loader_pkg::*;
#(
    parameter int CMD_ADDR_WIDTH  = 8,
    parameter int MEM_TO_CMD      = 4,
    parameter int WAVE_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WAVE_ADDR_WIDTH:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_write_en,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int LANE_W = $clog2(MEM_TO_CMD);
    localparam int IDX_W  = WAVE_ADDR_WIDTH + LANE_W;
    localparam int ADDR_W = WAVE_ADDR_WIDTH + 1;

    state_e                     state_q;
    mode_e                      mode_q;
    logic [WAVE_ADDR_WIDTH-1:0] start_q;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           idx_d;
    logic [IDX_W-1:0]           last_idx_q;
    logic                       s_ready_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic                       we_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       err_q;

    logic                       xfer;
    logic                       hdr_wave;
    logic [HDR_LEN_W-1:0]       hdr_len;
    logic [WAVE_ADDR_WIDTH-1:0] hdr_start;
    logic [IDX_W-1:0]           hdr_last_idx;
    logic                       hdr_bad;
    logic [ADDR_W-1:0]          gen_addr;
    logic                       gen_in_range;

    assign xfer      = s_valid && s_ready_q;
    assign hdr_wave  = s_data[HDR_MODE_BIT];
    assign hdr_len   = s_data[HDR_LEN_LSB +: HDR_LEN_W];
    assign hdr_start = s_data[HDR_START_LSB +: WAVE_ADDR_WIDTH];
    assign hdr_bad   = hdr_is_bad(hdr_wave, hdr_start, hdr_len);
    assign idx_d     = idx_q + 1'b1;

    // Index of the final payload word: LEN in wave mode, a whole number of
    // commands minus one in command mode.
    assign hdr_last_idx = hdr_wave ? IDX_W'(hdr_len)
                                   : IDX_W'({hdr_len, {LANE_W{1'b1}}});

    mem_write_addr_gen #(
        .CMD_ADDR_WIDTH (CMD_ADDR_WIDTH),
        .MEM_TO_CMD     (MEM_TO_CMD),
        .WAVE_ADDR_WIDTH(WAVE_ADDR_WIDTH)
    ) u_addr_gen (
        .mode_wave(mode_q == MODE_WAVE),
        .start    (start_q),
        .word_idx (idx_q),
        .addr     (gen_addr),
        .in_range (gen_in_range)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_CMD;
            start_q    <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            s_ready_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (xfer) begin
                        mode_q     <= mode_e'(hdr_wave);
                        start_q    <= hdr_start;
                        idx_q      <= '0;
                        last_idx_q <= hdr_last_idx;
                        err_q      <= hdr_bad;
                        busy_q     <= 1'b1;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        // Out-of-range words are swallowed so the stream stays aligned.
                        we_q  <= gen_in_range;
                        idx_q <= idx_d;
                        if (gen_in_range) begin
                            addr_q <= gen_addr;
                            data_q <= s_data;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (idx_q == last_idx_q) begin
                            s_ready_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready        = s_ready_q;
    assign mem_write_addr = addr_q;
    assign mem_write_data = data_q;
    assign mem_write_en   = we_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_mem_write_loader.sv
// Directed and randomized bursts for mem_write_loader, checked cycle by cycle
// against an arithmetic reference model of the loader's stream rules.
module tb_mem_write_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [12:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    mem_write_loader dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en  (mem_write_en),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    string step_tag = "init";

    // Reference model state
    bit          m_in_burst = 0;
    bit          m_fin      = 0;
    bit          m_ready    = 0;
    bit          m_err      = 0;
    bit          m_wave     = 0;
    int          m_start, m_len, m_total, m_k;
    bit          e_we   = 0;
    bit          e_done = 0;
    int          e_addr = 0;
    logic [31:0] e_data = '0;
    int          last_tries;

    logic [12:0] log_addr[$];
    logic [31:0] log_data[$];
    int          exp_a[$];
    logic [31:0] exp_d[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s/%s: observed=0x%0h expected=0x%0h", step_tag, tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(m_in_burst || m_fin));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(m_err));
        chk("mem_write_en", 32'(mem_write_en), 32'(e_we));
        if (e_we) begin
            chk("mem_write_addr", 32'(mem_write_addr), 32'(e_addr));
            chk("mem_write_data", mem_write_data, e_data);
        end
        if (mem_write_en === 1'b1) begin
            log_addr.push_back(mem_write_addr);
            log_data.push_back(mem_write_data);
        end
    endtask

    // One clock: drive, step the model on the edge, then compare.
    task automatic cycle(input bit v, input logic [31:0] d, output bit acc);
        int a;
        s_valid = v;
        s_data  = d;
        acc     = v && m_ready;
        @(posedge clk);
        #1;
        e_we   = 0;
        e_done = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (acc) begin
            if (!m_in_burst) begin
                m_wave  = d[31];
                m_len   = int'(d[27:16]);
                m_start = int'(d[11:0]);
                m_total = m_wave ? m_len + 1 : (m_len + 1) * 4;
                m_k     = 0;
                m_in_burst = 1;
                if (m_wave) m_err = (m_start + m_len) > 4095;
                else        m_err = (m_start > 255) || ((m_start % 256) + m_len > 255);
            end else begin
                if (m_wave) begin
                    a = m_start + m_k;
                    if (a <= 4095) begin e_we = 1; e_addr = 4096 + a; end
                end else begin
                    a = (m_start % 256) + m_k / 4;
                    if (a <= 255) begin e_we = 1; e_addr = (m_k % 4) * 256 + a; end
                end
                e_data = d;
                m_k++;
                if (m_k == m_total) begin
                    m_in_burst = 0;
                    m_fin      = 1;
                    e_done     = 1;
                end
            end
        end
        m_ready = !m_fin;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, $urandom, acc);
    endtask

    task automatic send_word(input logic [31:0] d, input int gap_pct);
        bit acc;
        int gaps;
        gaps = 0;
        while (gap_pct > 0 && gaps < 6 && $urandom_range(99, 0) < gap_pct) begin
            cycle(1'b0, $urandom, acc);
            gaps++;
        end
        acc = 0;
        last_tries = 0;
        while (!acc && last_tries < 8) begin
            cycle(1'b1, d, acc);
            last_tries++;
        end
    endtask

    task automatic do_reset(input int n, input bit v, input logic [31:0] d);
        reset   = 1'b1;
        s_valid = v;
        s_data  = d;
        repeat (n) begin
            @(posedge clk);
            #1;
            m_in_burst = 0; m_fin = 0; m_ready = 0; m_err = 0;
            e_we = 0; e_done = 0;
            check_outputs();
            chk("rst_addr", 32'(mem_write_addr), 32'd0);
            chk("rst_data", mem_write_data, 32'd0);
        end
        reset   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic check_log();
        chk("log_size", 32'(log_addr.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < log_addr.size(); i++) begin
            chk($sformatf("log_addr[%0d]", i), 32'(log_addr[i]), 32'(exp_a[i]));
            chk($sformatf("log_data[%0d]", i), log_data[i], exp_d[i]);
        end
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        bit acc;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;

        step_tag = "reset";
        do_reset(2, 1'b0, 32'h0);
        idle(2);
        log_addr.delete(); log_data.delete();

        step_tag = "cmd_burst";
        send_word(32'h0000_0010, 0);
        for (int i = 0; i < 4; i++) send_word(32'hA0A0_0000 + i, 0);
        idle(2);
        exp_a = '{32'h010, 32'h110, 32'h210, 32'h310};
        exp_d = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        check_log();
        chk("err_clean", 32'(err), 32'd0);

        step_tag = "wave_gaps";
        send_word(32'h8002_0FFD, 0);
        for (int i = 0; i < 3; i++) send_word(32'hB000_0000 + i, 50);
        idle(2);
        exp_a = '{32'h1FFD, 32'h1FFE, 32'h1FFF};
        exp_d = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002};
        check_log();
        chk("err_clean", 32'(err), 32'd0);

        step_tag = "wave_ovf";
        send_word(32'h8003_0FFE, 0);
        for (int i = 0; i < 4; i++) send_word(32'hC000_0000 + i, 0);
        idle(2);
        exp_a = '{32'h1FFE, 32'h1FFF};
        exp_d = '{32'hC000_0000, 32'hC000_0001};
        check_log();
        chk("err_set", 32'(err), 32'd1);

        step_tag = "cmd_ovf";
        send_word(32'h0001_00FF, 0);
        for (int i = 0; i < 8; i++) send_word(32'hD000_0000 + i, 0);
        idle(2);
        exp_a = '{32'h0FF, 32'h1FF, 32'h2FF, 32'h3FF};
        exp_d = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
        check_log();
        chk("err_set", 32'(err), 32'd1);

        step_tag = "b2b";
        send_word(32'h8001_0FFF, 0);
        send_word(32'hE000_0000, 0);
        send_word(32'hE000_0001, 0);
        send_word(32'h8000_0010, 0);
        chk("hdr_stall_cycles", 32'(last_tries), 32'd2);
        chk("err_cleared", 32'(err), 32'd0);
        send_word(32'hE000_0002, 0);
        idle(2);
        exp_a = '{32'h1FFF, 32'h1010};
        exp_d = '{32'hE000_0000, 32'hE000_0002};
        check_log();

        step_tag = "reset_mid";
        send_word(32'h8009_0100, 0);
        for (int i = 0; i < 3; i++) send_word(32'hF000_0000 + i, 0);
        do_reset(1, 1'b1, 32'hF000_0003);
        chk("busy_after_rst", 32'(busy), 32'd0);
        send_word(32'h8000_0000, 0);
        send_word(32'h1234_5678, 0);
        idle(2);
        exp_a = '{32'h1100, 32'h1101, 32'h1102, 32'h1000};
        exp_d = '{32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'h1234_5678};
        check_log();

        step_tag = "random";
        for (int b = 0; b < 40; b++) begin
            logic [31:0] hdr;
            int len, start, nw, gap;
            gap = $urandom_range(40, 0);
            if ($urandom_range(1, 0) == 1) begin
                len   = $urandom_range(7, 0);
                start = ($urandom_range(1, 0) == 1) ? $urandom_range(4095, 4085) : $urandom_range(4095, 0);
                hdr   = 32'h8000_0000 | (32'(len) << 16) | 32'(start) | (32'($urandom_range(7, 0)) << 28);
                nw    = len + 1;
            end else begin
                len   = $urandom_range(3, 0);
                start = ($urandom_range(1, 0) == 1) ? $urandom_range(255, 250) : $urandom_range(255, 0);
                hdr   = (32'(len) << 16) | 32'(start) | (32'($urandom_range(15, 0)) << 12);
                nw    = (len + 1) * 4;
            end
            send_word(hdr, gap);
            for (int i = 0; i < nw; i++) send_word($urandom, gap);
            if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
        end
        idle(3);
        cycle(1'b0, 32'h0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
